prime_check_sched: RTL
======================

# prime_check_sched

Round-robin scheduler that shares one iterative prime-check engine among four requesters. It accepts 10-bit candidate numbers, issues each to the engine with a start/done handshake, and returns a one-cycle result pulse to the granted requester. It also keeps running totals of checks completed and primes found. It sits between the client blocks and the single trial-division engine in the prime-search datapath.

## Interface
- NREQ, 4: number of requesters. Fixed at 4 for this revision.
- NUMMAX, 1000: largest legal candidate number.
- SysClk  in  1  system clock. All state updates on the rising edge.
- Reset  in  1  synchronous reset, active-high. Sampled on the SysClk rising edge.
- ReqValid  in  4  per-requester request. Held high until accepted.
- ReqNum  in  40  candidate numbers. Requester r uses bits [10r+9:10r].
- ReqReady  out  4  one-hot accept pulse to the granted requester. Combinational.
- EngStart  out  1  one-cycle start pulse to the engine. Registered.
- EngNum  out  10  number under check. Held stable from EngStart until EngDone.
- EngDone  in  1  engine result-valid pulse. Arrives at least 1 cycle after EngStart.
- EngPrime  in  1  engine verdict. Valid only when EngDone=1.
- RspValid  out  4  one-hot result pulse, one cycle, to the requester that issued the check.
- RspNum  out  10  number the result refers to.
- RspPrime  out  1  1 when RspNum is prime.
- RspErr  out  1  1 when the request was rejected as out of range.
- ChecksDone  out  16  count of engine checks completed. Wraps at 2^16.
- NumberofPrimesFound  out  8  count of prime results. Saturates at 255.

## Operation
States: IDLE, ISSUE, WAIT_DONE, RESPOND.

- **IDLE**
  - If no ReqValid bit is set, stay in IDLE.
  - Otherwise, grant g is the first requester with ReqValid set, searching upward from pointer Ptr and wrapping 3 to 0.
  - ReqReady[g]=1 in this cycle only. Latch g and ReqNum[g] into Num.
  - If Num is 0 or greater than NUMMAX: set the error flag and go to RESPOND. The engine is not used.
  - Otherwise go to ISSUE.
- **ISSUE**
  - EngStart=1 for exactly this cycle. EngNum=Num.
  - Go to WAIT_DONE.
  - EngDone is ignored in this state.
- **WAIT_DONE**
  - Hold EngNum.
  - When EngDone=1: latch EngPrime, increment ChecksDone, go to RESPOND.
- **RESPOND**
  - RspValid[g]=1. RspNum=Num, RspPrime=latched verdict (0 on error), RspErr=error flag.
  - If RspPrime=1 and NumberofPrimesFound is below 255, increment NumberofPrimesFound.
  - Set Ptr=(g+1) mod 4. Clear the error flag. Go to IDLE.
- EngDone outside WAIT_DONE is ignored. Nothing is latched and no counter changes.
- ReqReady is 0 in every state except IDLE.
- ReqValid going low before acceptance drops that request silently.
- Numbers 1 and 2 are legal. Prime/non-prime is decided entirely by the engine.

## Timing
- **Reset values:** state IDLE, Ptr=0, ReqReady=0, EngStart=0, EngNum=0, RspValid=0, RspNum=0, RspPrime=0, RspErr=0, ChecksDone=0, NumberofPrimesFound=0.
- **Reset mid-operation** (any state): everything returns to reset values on the next edge. An in-flight request is discarded and gets no response. A late EngDone arriving afterwards is ignored.
- **Legal request latency:** accept in cycle T, EngStart in T+1, EngDone in T+1+k (k≥1), RspValid in T+2+k.
- **Out-of-range request latency:** accept in cycle T, RspValid with RspErr=1 in T+1.
- **Throughput:** the next accept happens no earlier than the cycle after RSPOND, i.e. T+3+k for a legal request.
- **Response outputs:** RspNum, RspPrime and RspErr are meaningful only while RspValid≠0. Otherwise they hold their last values.
- **Fairness:** all four requesters held high are served in order Ptr, Ptr+1, …, so no requester waits more than 3 other services.
- **Counter boundaries:**
  - ChecksDone wraps from 65535 to 0.
  - NumberofPrimesFound stays at 255 once reached.
  - RESPOND and a new accept never share a cycle.

## Test plan
- After Reset, ReqValid=4'b0010, ReqNum[1]=7, engine answers EngDone=1/EngPrime=1 three cycles after EngStart -> ReqReady=4'b0010 at T, EngStart at T+1 with EngNum=7, RspValid=4'b0010 with RspNum=7, RspPrime=1, RspErr=0 at T+5, NumberofPrimesFound=1, ChecksDone=1.
- All four ReqValid held high with numbers 4, 5, 6, 7 -> grants in order 0, 1, 2, 3, then 0 again. RspPrime sequence 0, 1, 0, 1. NumberofPrimesFound=2.
- ReqNum=0, then ReqNum=1001, on requester 2 -> RspValid=4'b0100, RspErr=1, RspPrime=0 one cycle after each accept. No EngStart. Counters unchanged.
- Reset asserted while in WAIT_DONE for number 997, then EngDone=1 pulsed the next cycle -> no RspValid, counters stay 0, state IDLE, Ptr=0.
- Spurious EngDone in IDLE and ISSUE -> no state change, no count. Then 300 prime requests (e.g. 2 repeatedly) -> NumberofPrimesFound saturates at 255 and ChecksDone=300.

Source files
------------

// File: rtl/prime_check_sched_if.sv
// Bus bundle between the prime-check scheduler, its four requesters and the
// shared trial-division engine.
interface prime_check_sched_if #(
    parameter int NREQ = 4,
    parameter int NW   = 10
);
    // Request side: ReqValid[r] is held until the one-cycle ReqReady[r] pulse;
    // a transfer happens only in a cycle where both are high, and dropping
    // ReqValid before that cycle withdraws the request with no response.
    logic [NREQ-1:0]    ReqValid;
    logic [NREQ*NW-1:0] ReqNum;
    logic [NREQ-1:0]    ReqReady;

    logic               EngStart;
    logic [NW-1:0]      EngNum;
    logic               EngDone;
    logic               EngPrime;

    logic [NREQ-1:0]    RspValid;
    logic [NW-1:0]      RspNum;
    logic               RspPrime;
    logic               RspErr;

    logic [15:0]        ChecksDone;
    logic [7:0]         NumberofPrimesFound;

    // slave: the scheduler itself
    modport slave (
        input  ReqValid, ReqNum, EngDone, EngPrime,
        output ReqReady, EngStart, EngNum, RspValid, RspNum, RspPrime, RspErr,
        output ChecksDone, NumberofPrimesFound
    );

    // master: requesters plus engine, as seen from outside the scheduler
    modport master (
        output ReqValid, ReqNum, EngDone, EngPrime,
        input  ReqReady, EngStart, EngNum, RspValid, RspNum, RspPrime, RspErr,
        input  ChecksDone, NumberofPrimesFound
    );
endinterface

// File: rtl/prime_check_sched.sv
// Round-robin scheduler sharing one iterative prime-check engine among NREQ
// requesters, with running totals of checks completed and primes found.
module prime_check_sched #(
    parameter int NREQ   = 4,
    parameter int NW     = 10,
    parameter int NUMMAX = 1000
) (
    input  logic                     SysClk,
    input  logic                     Reset,
    prime_check_sched_if.slave       bus,
    output logic [1:0]               dbg_state_o,
    output logic [$clog2(NREQ)-1:0]  dbg_ptr_o
);
    localparam int PW = $clog2(NREQ);
    localparam logic [NW-1:0] NUM_MAX = NW'(NUMMAX);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_RESPOND   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   grant_q, grant_d;
    logic [NW-1:0]   num_q, num_d;
    logic            err_q, err_d;
    logic            eng_start_q, eng_start_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [NW-1:0]   rsp_num_q, rsp_num_d;
    logic            rsp_prime_q, rsp_prime_d;
    logic            rsp_err_q, rsp_err_d;
    logic [15:0]     checks_q, checks_d;
    logic [7:0]      primes_q, primes_d;

    logic [NW-1:0]   req_num_a [NREQ];
    logic            req_any;
    logic            pick_found;
    logic [PW-1:0]   pick;
    logic [PW-1:0]   scan_idx;
    logic [NW-1:0]   pick_num;
    logic            pick_bad;
    logic [NREQ-1:0] req_ready;

    function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
        return NREQ'(1) << idx;
    endfunction

    for (genvar r = 0; r < NREQ; r++) begin : g_slice
        assign req_num_a[r] = bus.ReqNum[r*NW +: NW];
    end

    // Rotating priority: first set request at or above ptr_q, wrapping.
    // NREQ is a power of two so the PW-bit add wraps naturally.
    always_comb begin
        req_any    = |bus.ReqValid;
        pick_found = 1'b0;
        pick       = ptr_q;
        scan_idx   = ptr_q;
        for (int i = 0; i < NREQ; i++) begin
            scan_idx = ptr_q + PW'(i);
            if (!pick_found && bus.ReqValid[scan_idx]) begin
                pick_found = 1'b1;
                pick       = scan_idx;
            end
        end
        pick_num = req_num_a[pick];
        pick_bad = (pick_num == '0) || (pick_num > NUM_MAX);
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        num_d       = num_q;
        err_d       = err_q;
        eng_start_d = 1'b0;
        rsp_valid_d = '0;
        rsp_num_d   = rsp_num_q;
        rsp_prime_d = rsp_prime_q;
        rsp_err_d   = rsp_err_q;
        checks_d    = checks_q;
        primes_d    = primes_q;
        req_ready   = '0;

        case (state_q)
            S_IDLE: begin
                if (req_any) begin
                    req_ready = onehot(pick);
                    grant_d   = pick;
                    num_d     = pick_num;
                    if (pick_bad) begin
                        // Out-of-range numbers bypass the engine entirely.
                        err_d       = 1'b1;
                        state_d     = S_RESPOND;
                        rsp_valid_d = onehot(pick);
                        rsp_num_d   = pick_num;
                        rsp_prime_d = 1'b0;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d     = S_ISSUE;
                        eng_start_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (bus.EngDone) begin
                    checks_d    = checks_q + 16'd1;
                    state_d     = S_RESPOND;
                    rsp_valid_d = onehot(grant_q);
                    rsp_num_d   = num_q;
                    rsp_prime_d = bus.EngPrime;
                    rsp_err_d   = err_q;
                end
            end
            S_RESPOND: begin
                if (rsp_prime_q && (primes_q != 8'hFF)) begin
                    primes_d = primes_q + 8'd1;
                end
                ptr_d   = grant_q + PW'(1);
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge SysClk) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            num_q       <= '0;
            err_q       <= 1'b0;
            eng_start_q <= 1'b0;
            rsp_valid_q <= '0;
            rsp_num_q   <= '0;
            rsp_prime_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            checks_q    <= '0;
            primes_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            num_q       <= num_d;
            err_q       <= err_d;
            eng_start_q <= eng_start_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_num_q   <= rsp_num_d;
            rsp_prime_q <= rsp_prime_d;
            rsp_err_q   <= rsp_err_d;
            checks_q    <= checks_d;
            primes_q    <= primes_d;
        end
    end

    assign bus.ReqReady            = req_ready;
    assign bus.EngStart            = eng_start_q;
    assign bus.EngNum              = num_q;
    assign bus.RspValid            = rsp_valid_q;
    assign bus.RspNum              = rsp_num_q;
    assign bus.RspPrime            = rsp_prime_q;
    assign bus.RspErr              = rsp_err_q;
    assign bus.ChecksDone          = checks_q;
    assign bus.NumberofPrimesFound = primes_q;

    assign dbg_state_o = state_q;
    assign dbg_ptr_o   = ptr_q;
endmodule
